// File: rtl/event_recorder.sv
// Alarm event recorder: edge-detects armed/siren_active, timestamps each event
// and queues it in an 8-entry show-ahead FIFO with a saturating lost-event count.
module event_recorder (
  input  logic        clock,
  input  logic        reset,
  input  logic        armed,
  input  logic        siren_active,
  input  logic        one_hz_enable,
  input  logic        clear,
  input  logic        pop,
  output logic [13:0] rd_data,
  output logic        empty,
  output logic        full,
  output logic [3:0]  count,
  output logic [7:0]  overflow,
  output logic [11:0] seconds
);
  localparam int unsigned TS_W    = 12;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned ENTRY_W = TYPE_W + TS_W;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned PTR_W   = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OVF_W   = 8;
  localparam int unsigned N_TYPES = 4;

  // Event type codes double as pending-bit indices.
  localparam logic [TYPE_W-1:0] T_ARMED     = 2'd0;
  localparam logic [TYPE_W-1:0] T_DISARMED  = 2'd1;
  localparam logic [TYPE_W-1:0] T_ALARM     = 2'd2;
  localparam logic [TYPE_W-1:0] T_ALARM_CLR = 2'd3;

  logic                 armed_q, siren_q;
  logic [N_TYPES-1:0]   pend_q;
  logic [TS_W-1:0]      pend_ts_q [N_TYPES];
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     cnt_q;
  logic [OVF_W-1:0]     ovf_q;
  logic [TS_W-1:0]      sec_q;

  logic [N_TYPES-1:0]   edges, collide, cand, sel_mask, pend_next;
  logic [TYPE_W-1:0]    sel;
  logic [TS_W-1:0]      sel_ts;
  logic                 any_cand, do_pop, do_push, drop;
  logic [2:0]           ovf_inc;
  logic [OVF_W:0]       ovf_sum;
  logic [OVF_W-1:0]     ovf_next;
  logic [CNT_W-1:0]     cnt_next;

  // Edge detect against last cycle's levels; new edges bypass straight into selection.
  always_comb begin
    edges              = '0;
    edges[T_ARMED]     = armed & ~armed_q;
    edges[T_DISARMED]  = ~armed & armed_q;
    edges[T_ALARM]     = siren_active & ~siren_q;
    edges[T_ALARM_CLR] = ~siren_active & siren_q;
    collide            = edges & pend_q;
    cand               = pend_q | edges;
    any_cand           = |cand;
  end

  // Priority: ALARM > ALARM_CLR > ARMED > DISARMED.
  always_comb begin
    sel = T_DISARMED;
    if (cand[T_ALARM])          sel = T_ALARM;
    else if (cand[T_ALARM_CLR]) sel = T_ALARM_CLR;
    else if (cand[T_ARMED])     sel = T_ARMED;
    sel_mask = any_cand ? (N_TYPES'(1) << sel) : '0;
    sel_ts   = pend_q[sel] ? pend_ts_q[sel] : sec_q;
  end

  // FIFO handshake, lost-event accounting and occupancy.
  always_comb begin
    do_pop    = pop & (cnt_q != '0);
    do_push   = any_cand & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
    drop      = any_cand & ~do_push;
    pend_next = cand & ~sel_mask;
    ovf_inc   = 3'(collide[0]) + 3'(collide[1]) + 3'(collide[2]) + 3'(collide[3]) + 3'(drop);
    ovf_sum   = (OVF_W+1)'(ovf_q) + (OVF_W+1)'(ovf_inc);
    ovf_next  = (ovf_sum > (OVF_W+1)'(255)) ? OVF_W'(255) : ovf_sum[OVF_W-1:0];
    cnt_next  = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_next = cnt_q + CNT_W'(1);
      2'b01:   cnt_next = cnt_q - CNT_W'(1);
      default: cnt_next = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
      siren_q <= 1'b0;
      pend_q  <= '0;
      for (int t = 0; t < N_TYPES; t++) pend_ts_q[t] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      sec_q   <= '0;
    end else begin
      armed_q <= armed;
      siren_q <= siren_active;
      if (clear) begin
        pend_q <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt_q  <= '0;
        ovf_q  <= '0;
        sec_q  <= '0;
      end else begin
        pend_q <= pend_next;
        for (int t = 0; t < N_TYPES; t++)
          if (edges[t] && !pend_q[t]) pend_ts_q[t] <= sec_q;
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        cnt_q <= cnt_next;
        ovf_q <= ovf_next;
        if (one_hz_enable) sec_q <= sec_q + TS_W'(1);
      end
    end
  end

  // Storage array needs no reset: rd_data is masked while empty.
  always_ff @(posedge clock) begin
    if (!clear && do_push) mem[wr_ptr] <= {sel, sel_ts};
  end

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign seconds  = sec_q;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/event_recorder.md
EVENT_RECORDER -- requirements
Module: event_recorder

Interface
REQ-001 SHALL have ports: clock  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
REQ-003 SHALL have ports: armed  in  1  debounced alarm-armed level from the alarm FSM.
REQ-004 SHALL have ports: siren_active  in  1  level, high while the siren generator is enabled.
REQ-005 SHALL have ports: one_hz_enable  in  1  one-cycle pulse once per second from the timer.
REQ-006 SHALL have ports: clear  in  1  synchronous clear of FIFO, timestamp and overflow count.
REQ-007 SHALL have ports: pop  in  1  consume head entry when not empty.
REQ-008 SHALL have ports: rd_data  out  14  head entry {type[13:12], timestamp[11:0]}; 0 when empty.
REQ-009 SHALL have ports: empty  out  1, full  out  1, count  out  4 (0..8 entries held).
REQ-010 SHALL have ports: overflow  out  8  saturating count of events lost to a full FIFO.
REQ-011 SHALL have ports: seconds  out  12  current timestamp value for the 7-segment display.

Function
REQ-012 Timestamp SHALL increment by 1 on each clock where one_hz_enable=1; 4095 wraps to 0.
REQ-013 Edge detection SHALL use registered copies of armed and siren_active; first cycle after reset compares against 0.
REQ-014 Event types SHALL be: 00 ARMED (armed rise), 01 DISARMED (armed fall), 10 ALARM (siren_active rise), 11 ALARM_CLR (siren_active fall).
REQ-015 Each detected edge SHALL set a per-type pending bit; the pending bit's captured timestamp SHALL be the seconds value in the edge cycle.
REQ-016 At most one pending event SHALL be written per cycle; priority ALARM > ALARM_CLR > ARMED > DISARMED; the written pending bit clears in that cycle.
REQ-017 An edge on a type whose pending bit is already set SHALL increment overflow and keep the older pending timestamp.
REQ-018 Write latency: event enters FIFO on the cycle after its edge (if highest-priority pending and not full); count updates the same edge.
REQ-019 FIFO SHALL be 8 entries, first-in first-out, circular 3-bit read/write pointers plus 4-bit count.
REQ-020 When full and no pop, highest-priority pending event SHALL be discarded, its pending bit cleared, overflow incremented.
REQ-021 pop with empty=1 SHALL be ignored; no pointer or count change.
REQ-022 Simultaneous push and pop when full SHALL both succeed; count stays 8, no overflow.
REQ-023 Simultaneous push and pop when empty SHALL push only; rd_data valid the next cycle.
REQ-024 overflow SHALL saturate at 255.
REQ-025 rd_data, empty, full SHALL be derived from registered state (show-ahead, no extra latency after write).
REQ-026 clear SHALL have priority over pop, push and timestamp increment in the same cycle; edges in that cycle are lost and edge registers still update.

Reset
REQ-027 reset=0 SHALL force: pointers=0, count=0, empty=1, full=0, rd_data=0, overflow=0, seconds=0, pending bits=0, edge registers=0.
REQ-028 Reset mid-operation SHALL discard all stored and pending events; no event generated by the reset itself.

Verification
REQ-029 Reset, 3 one_hz pulses, armed 0->1 -> next cycle count=1, rd_data={00,12'd3}, empty=0.
REQ-030 armed and siren_active rise same cycle at seconds=5 -> {10,5} written first, {00,5} next cycle, count=2.
REQ-031 Ten ARMED/DISARMED events with no pop -> count=8, full=1, overflow=2, head={00,first timestamp}.
REQ-032 Full FIFO, pop and new event same cycle -> count stays 8, overflow unchanged, head advances one entry.
REQ-033 seconds=4095 plus one_hz pulse -> seconds=0; subsequent event timestamp 0.
REQ-034 Three stored events, clear=1 with pop=1 and armed edge -> count=0, empty=1, seconds=0, overflow=0, no entry written.
